// File: rtl/data_memory_if.sv
// Load/store bus between the datapath and the data memory: address, enables,
// write data and registered read data.
interface data_memory_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] data_inputs;
   logic [DATA_WIDTH-1:0] data_outputs;

   modport master (output address, read, write, data_inputs, input data_outputs);
   modport slave  (input address, read, write, data_inputs, output data_outputs);
endinterface

// File: rtl/data_memory.sv
// 2^ADDR_WIDTH x DATA_WIDTH synchronous data memory with a registered read port
// and write-through on simultaneous read/write; async reset clears everything.
module data_memory #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [DATA_WIDTH-1:0]            rd_q;

   // The whole array must clear on reset, so storage is flops rather than a RAM macro.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '0;
      end else if (bus.write) begin
         mem[bus.address] <= bus.data_inputs;
      end
   end

   // Write-through takes priority so a combined access returns the new data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q <= '0;
      end else if (bus.read && bus.write) begin
         rd_q <= bus.data_inputs;
      end else if (bus.read) begin
         rd_q <= mem[bus.address];
      end
   end

   assign bus.data_outputs = rd_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, read-back, hold, write-through,
// address boundaries and reset during operation.
module tb_data_memory;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one access at the falling edge, let the rising edge take it,
   // then drop the enables 1 time unit later.
   task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.read        = r;
      bus.write       = w;
      bus.address     = a;
      bus.data_inputs = d;
      @(posedge clk);
      #1;
      bus.read  = 1'b0;
      bus.write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      vectors++;
      if (bus.data_outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_out: got %h expected 00", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'h00, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_rd00: got %h expected 00", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'hFF, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_rdFF: got %h expected 00", bus.data_outputs);
      end
   endtask

   task automatic test_write_read();
      access(1'b0, 1'b1, 8'h02, 8'h55);
      access(1'b0, 1'b1, 8'h0A, 8'hCC);
      access(1'b1, 1'b0, 8'h02, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h55) begin
         miscompares++;
         $display("FAIL rd_02: got %h expected 55", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'h0A, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'hCC) begin
         miscompares++;
         $display("FAIL rd_0A: got %h expected cc", bus.data_outputs);
      end
   endtask

   task automatic test_hold();
      access(1'b0, 1'b0, 8'h0A, 8'hEE);
      access(1'b0, 1'b0, 8'h33, 8'h44);
      vectors++;
      if (bus.data_outputs !== 8'hCC) begin
         miscompares++;
         $display("FAIL hold_idle: got %h expected cc", bus.data_outputs);
      end
      access(1'b0, 1'b1, 8'h05, 8'h11);
      vectors++;
      if (bus.data_outputs !== 8'hCC) begin
         miscompares++;
         $display("FAIL hold_write: got %h expected cc", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'h05, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h11) begin
         miscompares++;
         $display("FAIL rd_05: got %h expected 11", bus.data_outputs);
      end
   endtask

   task automatic test_simultaneous();
      access(1'b1, 1'b1, 8'h0A, 8'h3C);
      vectors++;
      if (bus.data_outputs !== 8'h3C) begin
         miscompares++;
         $display("FAIL wr_through: got %h expected 3c", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'h05, 8'h00);
      access(1'b1, 1'b0, 8'h0A, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h3C) begin
         miscompares++;
         $display("FAIL rd_0A_after_wt: got %h expected 3c", bus.data_outputs);
      end
   endtask

   task automatic test_boundaries();
      access(1'b0, 1'b1, 8'h00, 8'hAA);
      access(1'b0, 1'b1, 8'hFF, 8'h77);
      access(1'b1, 1'b0, 8'h00, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'hAA) begin
         miscompares++;
         $display("FAIL rd_00: got %h expected aa", bus.data_outputs);
      end
      access(1'b1, 1'b0, 8'hFF, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h77) begin
         miscompares++;
         $display("FAIL rd_FF: got %h expected 77", bus.data_outputs);
      end
      access(1'b0, 1'b1, 8'h00, 8'h01);
      access(1'b1, 1'b0, 8'h00, 8'h00);
      vectors++;
      if (bus.data_outputs !== 8'h01) begin
         miscompares++;
         $display("FAIL overwrite_00: got %h expected 01", bus.data_outputs);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] addrs [4];
      addrs = '{8'h02, 8'h0A, 8'hFF, 8'h40};
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.data_outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_async_out: got %h expected 00", bus.data_outputs);
      end
      // Write attempted on an edge while reset is still asserted.
      @(negedge clk);
      bus.write       = 1'b1;
      bus.address     = 8'h40;
      bus.data_inputs = 8'h99;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         access(1'b1, 1'b0, addrs[i], 8'h00);
         vectors++;
         if (bus.data_outputs !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_rd[%h]: got %h expected 00", addrs[i], bus.data_outputs);
         end
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      bus.read        = 1'b0;
      bus.write       = 1'b0;
      bus.address     = '0;
      bus.data_inputs = '0;
      test_reset();
      test_write_read();
      test_hold();
      test_simultaneous();
      test_boundaries();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
